// File: rtl/css_mcu0_dmi_arb_pkg.sv
// Shared types and constants for the MCU0 DMI register-port arbiter.
package css_mcu0_dmi_arb_pkg;

   localparam int unsigned DMI_ADDR_W = 7;
   localparam int unsigned DMI_DATA_W = 32;
   localparam int unsigned CNT_W      = 4;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } arb_state_t;

   typedef struct packed {
      logic                  write;
      logic [DMI_ADDR_W-1:0] addr;
      logic [DMI_DATA_W-1:0] wdata;
   } dmi_req_t;

   typedef logic req_id_t;

endpackage

// File: rtl/css_mcu0_dmi_rr_arb2.sv
// Two-way round-robin grant; last_gnt only moves when the caller takes the grant.
module css_mcu0_dmi_rr_arb2
   import css_mcu0_dmi_arb_pkg::*;
(
   input  logic    clk,
   input  logic    rst,
   input  logic    req0,
   input  logic    req1,
   input  logic    update_en,
   output logic    gnt_any,
   output req_id_t gnt_id
);

   req_id_t last_gnt;

   // Remember who won last; reset to 1 so requester 0 wins the first tie.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_gnt <= 1'b1;
      end else if (update_en && gnt_any) begin
         last_gnt <= gnt_id;
      end
   end

   // Single requester wins outright; on a tie the one not granted last wins.
   always_comb begin
      gnt_any = req0 | req1;
      gnt_id  = (req0 && req1) ? ~last_gnt : req1;
   end

endmodule

// File: rtl/css_mcu0_dmi_arbiter.sv
// Serialises two requesters onto the single debug-module DMI register port.
module css_mcu0_dmi_arbiter
   import css_mcu0_dmi_arb_pkg::*;
#(
   parameter int unsigned RD_LAT = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  req0_valid,
   output logic                  req0_ready,
   input  logic                  req0_write,
   input  logic [DMI_ADDR_W-1:0] req0_addr,
   input  logic [DMI_DATA_W-1:0] req0_wdata,
   output logic                  rsp0_valid,
   output logic [DMI_DATA_W-1:0] rsp0_rdata,
   input  logic                  req1_valid,
   output logic                  req1_ready,
   input  logic                  req1_write,
   input  logic [DMI_ADDR_W-1:0] req1_addr,
   input  logic [DMI_DATA_W-1:0] req1_wdata,
   output logic                  rsp1_valid,
   output logic [DMI_DATA_W-1:0] rsp1_rdata,
   output logic                  dmi_reg_en,
   output logic                  dmi_reg_wr_en,
   output logic [DMI_ADDR_W-1:0] dmi_reg_addr,
   output logic [DMI_DATA_W-1:0] dmi_reg_wdata,
   input  logic [DMI_DATA_W-1:0] dmi_reg_rdata,
   output logic                  busy
);

   arb_state_t            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q;
   logic                  lat_write;
   req_id_t               id_q;
   logic [DMI_DATA_W-1:0] rsp_data_q;
   logic [DMI_DATA_W-1:0] rsp0_hold_q, rsp1_hold_q;
   logic                  gnt_any;
   req_id_t               gnt_id;
   logic                  grant;
   dmi_req_t              req_sel;

   css_mcu0_dmi_rr_arb2 u_rr (
      .clk       (clk),
      .rst       (rst),
      .req0      (req0_valid),
      .req1      (req1_valid),
      .update_en (grant),
      .gnt_any   (gnt_any),
      .gnt_id    (gnt_id)
   );

   // Grant qualification and selection of the winning request fields.
   always_comb begin
      grant   = (state_q == IDLE) && !flush && gnt_any;
      req_sel = gnt_id ? '{write: req1_write, addr: req1_addr, wdata: req1_wdata}
                       : '{write: req0_write, addr: req0_addr, wdata: req0_wdata};
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; flush overrides every state.
   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE:    if (gnt_any) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (cnt_q == CNT_W'(1)) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Request latch, latency counter and response capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lat_write     <= 1'b0;
         id_q          <= 1'b0;
         dmi_reg_addr  <= '0;
         dmi_reg_wdata <= '0;
         cnt_q         <= '0;
         rsp_data_q    <= '0;
         rsp0_hold_q   <= '0;
         rsp1_hold_q   <= '0;
      end else begin
         if (grant) begin
            lat_write     <= req_sel.write;
            dmi_reg_addr  <= req_sel.addr;
            dmi_reg_wdata <= req_sel.wdata;
            id_q          <= gnt_id;
         end
         if (flush) begin
            cnt_q <= '0;
         end else if (state_q == ISSUE) begin
            cnt_q <= RD_LAT[CNT_W-1:0];
         end else if (state_q == WAIT && cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
         end
         if (!flush && state_q == WAIT && cnt_q == CNT_W'(1)) begin
            rsp_data_q <= lat_write ? '0 : dmi_reg_rdata;
         end
         if (!flush && state_q == RESP) begin
            if (id_q) rsp1_hold_q <= rsp_data_q;
            else      rsp0_hold_q <= rsp_data_q;
         end
      end
   end

   // Outputs; the response data is shown live in RESP and held afterwards.
   always_comb begin
      req0_ready    = !rst && grant && (gnt_id == 1'b0);
      req1_ready    = !rst && grant && (gnt_id == 1'b1);
      dmi_reg_en    = (state_q == ISSUE) && !flush;
      dmi_reg_wr_en = dmi_reg_en && lat_write;
      rsp0_valid    = (state_q == RESP) && !flush && (id_q == 1'b0);
      rsp1_valid    = (state_q == RESP) && !flush && (id_q == 1'b1);
      rsp0_rdata    = rsp0_valid ? rsp_data_q : rsp0_hold_q;
      rsp1_rdata    = rsp1_valid ? rsp_data_q : rsp1_hold_q;
      busy          = (state_q != IDLE);
   end

endmodule

// File: tb/tb_css_mcu0_dmi_arbiter.sv
// Scoreboard bench: instance 0 uses RD_LAT=1, instance 1 uses RD_LAT=4.
module tb_css_mcu0_dmi_arbiter;

   typedef struct {
      int          port;
      logic [31:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst [2];
   logic        flush [2];
   logic        req0_valid [2], req0_ready [2], req0_write [2];
   logic [6:0]  req0_addr [2];
   logic [31:0] req0_wdata [2];
   logic        rsp0_valid [2];
   logic [31:0] rsp0_rdata [2];
   logic        req1_valid [2], req1_ready [2], req1_write [2];
   logic [6:0]  req1_addr [2];
   logic [31:0] req1_wdata [2];
   logic        rsp1_valid [2];
   logic [31:0] rsp1_rdata [2];
   logic        dmi_reg_en [2], dmi_reg_wr_en [2];
   logic [6:0]  dmi_reg_addr [2];
   logic [31:0] dmi_reg_wdata [2];
   logic [31:0] dmi_reg_rdata [2];
   logic        busy [2];

   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   exp_t q0[$];
   exp_t q1[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      css_mcu0_dmi_arbiter #(.RD_LAT((g == 0) ? 1 : 4)) u_dut (
         .clk           (clk),
         .rst           (rst[g]),
         .flush         (flush[g]),
         .req0_valid    (req0_valid[g]),
         .req0_ready    (req0_ready[g]),
         .req0_write    (req0_write[g]),
         .req0_addr     (req0_addr[g]),
         .req0_wdata    (req0_wdata[g]),
         .rsp0_valid    (rsp0_valid[g]),
         .rsp0_rdata    (rsp0_rdata[g]),
         .req1_valid    (req1_valid[g]),
         .req1_ready    (req1_ready[g]),
         .req1_write    (req1_write[g]),
         .req1_addr     (req1_addr[g]),
         .req1_wdata    (req1_wdata[g]),
         .rsp1_valid    (rsp1_valid[g]),
         .rsp1_rdata    (rsp1_rdata[g]),
         .dmi_reg_en    (dmi_reg_en[g]),
         .dmi_reg_wr_en (dmi_reg_wr_en[g]),
         .dmi_reg_addr  (dmi_reg_addr[g]),
         .dmi_reg_wdata (dmi_reg_wdata[g]),
         .dmi_reg_rdata (dmi_reg_rdata[g]),
         .busy          (busy[g])
      );
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push(input int d, input int p, input logic [31:0] v);
      exp_t e;
      e.port = p;
      e.data = v;
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
   endtask

   task automatic check_rsp(input int d, input int p, input logic [31:0] data);
      exp_t e;
      if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
         checks++;
         failures++;
         $display("FAIL unexpected_rsp dut=%0d port=%0d actual=%h required=no response", d, p, data);
      end else begin
         e = (d == 0) ? q0.pop_front() : q1.pop_front();
         chk($sformatf("rsp_port_dut%0d", d), 32'(p), 32'(e.port));
         chk($sformatf("rsp_data_dut%0d", d), data, e.data);
      end
   endtask

   // Monitor: every response pulse must match the head of that instance's queue.
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (rsp0_valid[d]) check_rsp(d, 0, rsp0_rdata[d]);
         if (rsp1_valid[d]) check_rsp(d, 1, rsp1_rdata[d]);
         if (req0_ready[d] || req1_ready[d]) chk("ready_only_idle", 32'(busy[d]), 32'd0);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   // Wait (bounded) for either ready on instance d; returns port and cycles waited.
   task automatic wait_any(input int d, output int port, output int waited);
      port   = -1;
      waited = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (req0_ready[d] || req1_ready[d]) begin
            chk("one_ready_only", 32'(req0_ready[d] & req1_ready[d]), 32'd0);
            port = req0_ready[d] ? 0 : 1;
            break;
         end
         waited++;
      end
      if (port < 0) begin
         checks++;
         failures++;
         $display("FAIL ready_timeout dut=%0d actual=no ready required=ready", d);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=still running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int p, w, t0, prev;
      for (int d = 0; d < 2; d++) begin
         rst[d] = 1'b1;  flush[d] = 1'b0;
         req0_valid[d] = 1'b0; req0_write[d] = 1'b0; req0_addr[d] = '0; req0_wdata[d] = '0;
         req1_valid[d] = 1'b0; req1_write[d] = 1'b0; req1_addr[d] = '0; req1_wdata[d] = '0;
         dmi_reg_rdata[d] = '0;
      end
      req0_valid[0] = 1'b1;
      smp();
      for (int d = 0; d < 2; d++) begin
         chk("rst_busy", 32'(busy[d]), 32'd0);
         chk("rst_reg_en", 32'(dmi_reg_en[d]), 32'd0);
         chk("rst_addr", 32'(dmi_reg_addr[d]), 32'd0);
         chk("rst_rsp_rdata", rsp0_rdata[d] | rsp1_rdata[d], 32'd0);
      end
      chk("rst_ready_gated", 32'(req0_ready[0]), 32'd0);
      step();
      req0_valid[0] = 1'b0;
      rst[0] = 1'b0; rst[1] = 1'b0;

      // Read from requester 0, RD_LAT=1
      step();
      req0_valid[0] = 1'b1; req0_write[0] = 1'b0; req0_addr[0] = 7'h11;
      dmi_reg_rdata[0] = 32'hDEADBEEF;
      wait_any(0, p, w);
      chk("t1_port", 32'(p), 32'd0);
      chk("t1_ready_t0", 32'(w), 32'd0);
      push(0, 0, 32'hDEADBEEF);
      step(); req0_valid[0] = 1'b0; smp();
      chk("t1_reg_en", 32'(dmi_reg_en[0]), 32'd1);
      chk("t1_addr", 32'(dmi_reg_addr[0]), 32'h11);
      chk("t1_wr_en", 32'(dmi_reg_wr_en[0]), 32'd0);
      step(); smp();
      chk("t1_reg_en_one_cycle", 32'(dmi_reg_en[0]), 32'd0);
      step(); smp();
      chk("t1_rsp0_t3", 32'(rsp0_valid[0]), 32'd1);
      chk("t1_rsp1_quiet", 32'(rsp1_valid[0]), 32'd0);
      step(); smp();
      chk("t1_rsp0_pulse", 32'(rsp0_valid[0]), 32'd0);
      chk("t1_rdata_hold", rsp0_rdata[0], 32'hDEADBEEF);

      // Write from requester 1
      step();
      req1_valid[0] = 1'b1; req1_write[0] = 1'b1; req1_addr[0] = 7'h10; req1_wdata[0] = 32'h1;
      dmi_reg_rdata[0] = 32'h12345678;
      wait_any(0, p, w);
      chk("t2_port", 32'(p), 32'd1);
      push(0, 1, 32'h0);
      step(); req1_valid[0] = 1'b0; smp();
      chk("t2_reg_en", 32'(dmi_reg_en[0]), 32'd1);
      chk("t2_wr_en", 32'(dmi_reg_wr_en[0]), 32'd1);
      chk("t2_wdata", dmi_reg_wdata[0], 32'h1);
      chk("t2_addr", 32'(dmi_reg_addr[0]), 32'h10);
      step(); smp();
      chk("t2_reg_en_one_cycle", 32'(dmi_reg_en[0]), 32'd0);
      step(); smp();
      chk("t2_rsp1", 32'(rsp1_valid[0]), 32'd1);
      step();

      // Both valid from reset: alternate grants spaced RD_LAT+3
      rst[0] = 1'b1;
      req0_valid[0] = 1'b1; req0_write[0] = 1'b0; req0_addr[0] = 7'h01;
      req1_valid[0] = 1'b1; req1_write[0] = 1'b0; req1_addr[0] = 7'h02;
      step();
      rst[0] = 1'b0;
      prev = 0;
      for (int k = 0; k < 6; k++) begin
         wait_any(0, p, w);
         chk("t3_grant_order", 32'(p), 32'(k % 2));
         if (k == 0) chk("t3_first_immediate", 32'(w), 32'd0);
         else        chk("t3_spacing", 32'(cyc - prev), 32'd4);
         prev = cyc;
         dmi_reg_rdata[0] = 32'hA000_0000 + 32'(k);
         push(0, p, 32'hA000_0000 + 32'(k));
         step();
         if (k == 5) begin
            req0_valid[0] = 1'b0;
            req1_valid[0] = 1'b0;
         end
      end
      repeat (5) step();
      chk("t3_drained", 32'(q0.size()), 32'd0);

      // Reset during ISSUE: strobe drops immediately, no response, tie to req0
      req0_valid[0] = 1'b1; req0_addr[0] = 7'h33;
      wait_any(0, p, w);
      chk("t4_port", 32'(p), 32'd0);
      step(); req0_valid[0] = 1'b0; smp();
      chk("t4_reg_en_issue", 32'(dmi_reg_en[0]), 32'd1);
      #1 rst[0] = 1'b1;
      #1;
      chk("t4_reg_en_async", 32'(dmi_reg_en[0]), 32'd0);
      chk("t4_busy_async", 32'(busy[0]), 32'd0);
      #1 rst[0] = 1'b0;
      step();
      req0_valid[0] = 1'b1; req1_valid[0] = 1'b1;
      dmi_reg_rdata[0] = 32'h0000_C0DE;
      wait_any(0, p, w);
      chk("t4_tie_after_rst", 32'(p), 32'd0);
      push(0, p, 32'h0000_C0DE);
      step(); req0_valid[0] = 1'b0; req1_valid[0] = 1'b0;
      repeat (5) step();
      chk("t4_drained", 32'(q0.size()), 32'd0);

      // RD_LAT=4: only the rdata present in cycle t0+5 is captured
      req0_valid[1] = 1'b1; req0_write[1] = 1'b0; req0_addr[1] = 7'h22;
      dmi_reg_rdata[1] = 32'h5000_0000;
      wait_any(1, p, w);
      chk("t5_port", 32'(p), 32'd0);
      t0 = cyc;
      push(1, 0, 32'h5000_0005);
      for (int off = 1; off <= 6; off++) begin
         step();
         if (off == 1) req0_valid[1] = 1'b0;
         dmi_reg_rdata[1] = 32'h5000_0000 + 32'(off);
         smp();
         if (off == 1) begin
            chk("t5_reg_en", 32'(dmi_reg_en[1]), 32'd1);
            chk("t5_addr", 32'(dmi_reg_addr[1]), 32'h22);
         end
         if (off == 5) chk("t5_no_early_rsp", 32'(rsp0_valid[1]), 32'd0);
         if (off == 6) chk("t5_rsp_t6", 32'(rsp0_valid[1]), 32'd1);
      end
      chk("t5_elapsed", 32'(cyc - t0), 32'd6);

      // Flush during WAIT: response dropped, last_gnt preserved
      step();
      req0_valid[1] = 1'b1; req0_addr[1] = 7'h44;
      wait_any(1, p, w);
      chk("t6_port", 32'(p), 32'd0);
      step(); req0_valid[1] = 1'b0;
      step();
      step(); flush[1] = 1'b1; smp();
      chk("t6_busy_in_flush", 32'(busy[1]), 32'd1);
      step(); flush[1] = 1'b0; smp();
      chk("t6_busy_after_flush", 32'(busy[1]), 32'd0);
      chk("t6_no_rsp", 32'(rsp0_valid[1]), 32'd0);
      step();
      req0_valid[1] = 1'b1; req1_valid[1] = 1'b1; req1_write[1] = 1'b0;
      dmi_reg_rdata[1] = 32'h0BAD_F00D;
      wait_any(1, p, w);
      chk("t6_tie_after_flush", 32'(p), 32'd1);
      push(1, p, 32'h0BAD_F00D);
      step(); req0_valid[1] = 1'b0; req1_valid[1] = 1'b0;
      repeat (10) step();
      chk("final_q0_empty", 32'(q0.size()), 32'd0);
      chk("final_q1_empty", 32'(q1.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
